// File: rtl/capture_readout.sv
// Capture buffer: stores controller samples, then replays them in order to firmware on rd_req.
// Read latency 1 cycle; no backpressure on writes (overflow/illegal accesses dropped and flagged).
module capture_readout #(
   parameter int FIFO_SIZE       = 1024,
   parameter int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       wr_vld,
   input  logic                       capture_done,
   input  logic                       clear,
   input  logic                       rewind,
   input  logic                       rd_req,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_data_vld,
   output logic                       rd_last,
   output logic [FIFO_SIZE_WIDTH-1:0] buf_count,
   output logic                       readout_ready,
   output logic                       event_wr_when_full,
   output logic                       event_wr_when_not_capturing,
   output logic                       event_rd_req_when_not_ready
);

   localparam int AW = $clog2(FIFO_SIZE);
   localparam logic [FIFO_SIZE_WIDTH-1:0] PTR_FULL = FIFO_SIZE_WIDTH'(FIFO_SIZE);
   localparam logic [FIFO_SIZE_WIDTH-1:0] PTR_ONE  = FIFO_SIZE_WIDTH'(1);

   localparam logic [1:0] ST_CAPTURE = 2'd0;
   localparam logic [1:0] ST_READOUT = 2'd1;
   localparam logic [1:0] ST_DRAINED = 2'd2;

   logic [1:0]                 state;
   logic                       done_q;
   logic [FIFO_SIZE_WIDTH-1:0] wr_ptr;
   logic [FIFO_SIZE_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0]      mem [FIFO_SIZE];

   logic capturing;
   logic reading;
   logic rewind_act;
   logic wr_accept;
   logic rd_accept;
   logic done_rise;

   assign capturing  = (state == ST_CAPTURE);
   assign reading    = (state == ST_READOUT);
   assign rewind_act = rewind && !capturing;
   assign wr_accept  = rstn && !clear && capturing && wr_vld && (wr_ptr != PTR_FULL);
   assign rd_accept  = !clear && !rewind_act && reading && rd_req;
   assign done_rise  = capture_done && !done_q;

   assign buf_count     = wr_ptr - rd_ptr;
   assign readout_ready = reading;

   // Storage is deliberately left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state                       <= ST_CAPTURE;
         done_q                      <= 1'b0;
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         rd_data                     <= '0;
         rd_data_vld                 <= 1'b0;
         rd_last                     <= 1'b0;
         event_wr_when_full          <= 1'b0;
         event_wr_when_not_capturing <= 1'b0;
         event_rd_req_when_not_ready <= 1'b0;
      end else begin
         done_q                      <= capture_done;
         rd_data_vld                 <= 1'b0;
         rd_last                     <= 1'b0;
         event_wr_when_full          <= !clear && capturing && wr_vld && (wr_ptr == PTR_FULL);
         event_wr_when_not_capturing <= !clear && !capturing && wr_vld;
         // A rewind swallows a same-cycle request silently, even in DRAINED.
         event_rd_req_when_not_ready <= !clear && !rewind_act && !reading && rd_req;

         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= ST_CAPTURE;
         end else begin
            case (state)
               ST_CAPTURE: begin
                  if (wr_accept) begin
                     wr_ptr <= wr_ptr + PTR_ONE;
                  end
                  if (done_rise) begin
                     state <= ((wr_ptr != '0) || wr_accept) ? ST_READOUT : ST_DRAINED;
                  end
               end
               ST_READOUT, ST_DRAINED: begin
                  if (rewind) begin
                     rd_ptr <= '0;
                     state  <= (wr_ptr == '0) ? ST_DRAINED : ST_READOUT;
                  end else if (rd_accept) begin
                     rd_data     <= mem[rd_ptr[AW-1:0]];
                     rd_data_vld <= 1'b1;
                     rd_ptr      <= rd_ptr + PTR_ONE;
                     if (rd_ptr == wr_ptr - PTR_ONE) begin
                        rd_last <= 1'b1;
                        state   <= ST_DRAINED;
                     end
                  end
               end
               default: state <= ST_CAPTURE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout with an 8-word buffer.
module tb_capture_readout;

   localparam int FS  = 8;
   localparam int FSW = $clog2(FS) + 1;
   localparam int DW  = 32;

   logic           clk = 1'b0;
   logic           rstn;
   logic [DW-1:0]  wr_data;
   logic           wr_vld;
   logic           capture_done;
   logic           clear;
   logic           rewind;
   logic           rd_req;
   logic [DW-1:0]  rd_data;
   logic           rd_data_vld;
   logic           rd_last;
   logic [FSW-1:0] buf_count;
   logic           readout_ready;
   logic           event_wr_when_full;
   logic           event_wr_when_not_capturing;
   logic           event_rd_req_when_not_ready;

   int checks = 0;
   int errors = 0;
   int fulls  = 0;

   capture_readout #(.FIFO_SIZE(FS), .FIFO_SIZE_WIDTH(FSW), .DATA_WIDTH(DW)) dut (
      .clk                         (clk),
      .rstn                        (rstn),
      .wr_data                     (wr_data),
      .wr_vld                      (wr_vld),
      .capture_done                (capture_done),
      .clear                       (clear),
      .rewind                      (rewind),
      .rd_req                      (rd_req),
      .rd_data                     (rd_data),
      .rd_data_vld                 (rd_data_vld),
      .rd_last                     (rd_last),
      .buf_count                   (buf_count),
      .readout_ready               (readout_ready),
      .event_wr_when_full          (event_wr_when_full),
      .event_wr_when_not_capturing (event_wr_when_not_capturing),
      .event_rd_req_when_not_ready (event_rd_req_when_not_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_data = d;
      wr_vld  = 1'b1;
      tick();
      wr_vld  = 1'b0;
   endtask

   task automatic capture_pulse();
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      chk("ready_rise", 64'(readout_ready), 64'd1);
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_count", 64'(buf_count), 64'd0);
   endtask

   // Streams n reads with rd_req held; expects base+i data, last on the final word.
   task automatic read_stream(input string tag, input int n, input logic [DW-1:0] base);
      rd_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_vld"},  64'(rd_data_vld), 64'd1);
         chk({tag, "_data"}, 64'(rd_data), 64'(base + DW'(i)));
         chk({tag, "_last"}, 64'(rd_last), (i == n - 1) ? 64'd1 : 64'd0);
      end
      rd_req = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; wr_data = '0; wr_vld = 1'b0; capture_done = 1'b0;
      clear = 1'b0; rewind = 1'b0; rd_req = 1'b0;
      tick();
      tick();
      chk("rst_data",  64'(rd_data), 64'd0);
      chk("rst_vld",   64'(rd_data_vld), 64'd0);
      chk("rst_last",  64'(rd_last), 64'd0);
      chk("rst_count", 64'(buf_count), 64'd0);
      chk("rst_ready", 64'(readout_ready), 64'd0);
      chk("rst_evf",   64'(event_wr_when_full), 64'd0);
      chk("rst_evw",   64'(event_wr_when_not_capturing), 64'd0);
      chk("rst_evr",   64'(event_rd_req_when_not_ready), 64'd0);
      rstn = 1'b1;

      // Fill and drain
      for (int i = 0; i < 8; i++) begin
         write_word(32'h100 + DW'(i));
         chk("fill_count", 64'(buf_count), 64'(i + 1));
      end
      capture_pulse();
      rd_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_vld",   64'(rd_data_vld), 64'd1);
         chk("drain_data",  64'(rd_data), 64'(32'h100 + i));
         chk("drain_last",  64'(rd_last), (i == 7) ? 64'd1 : 64'd0);
         chk("drain_count", 64'(buf_count), 64'(7 - i));
         chk("drain_ready", 64'(readout_ready), (i == 7) ? 64'd0 : 64'd1);
      end
      rd_req = 1'b0;
      tick();
      chk("drain_idle_vld", 64'(rd_data_vld), 64'd0);
      chk("drain_hold",     64'(rd_data), 64'h107);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("drained_evr", 64'(event_rd_req_when_not_ready), 64'd1);
      chk("drained_vld", 64'(rd_data_vld), 64'd0);
      tick();
      chk("drained_evr_pulse", 64'(event_rd_req_when_not_ready), 64'd0);

      // Overflow
      clear_pulse();
      chk("clear_ready", 64'(readout_ready), 64'd0);
      for (int i = 0; i < 10; i++) begin
         write_word(32'h200 + DW'(i));
         chk("ovf_evf", 64'(event_wr_when_full), (i >= 8) ? 64'd1 : 64'd0);
         if (event_wr_when_full === 1'b1) fulls++;
      end
      chk("ovf_pulses", 64'(fulls), 64'd2);
      chk("ovf_count",  64'(buf_count), 64'd8);
      capture_pulse();
      read_stream("ovf_rd", 8, 32'h200);

      // Illegal access
      clear_pulse();
      for (int i = 0; i < 3; i++) write_word(32'h300 + DW'(i));
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("ill_evr",   64'(event_rd_req_when_not_ready), 64'd1);
      chk("ill_vld",   64'(rd_data_vld), 64'd0);
      chk("ill_count", 64'(buf_count), 64'd3);
      capture_pulse();
      write_word(32'hDEAD);
      chk("ill_evw",    64'(event_wr_when_not_capturing), 64'd1);
      chk("ill_count2", 64'(buf_count), 64'd3);
      tick();
      chk("ill_evw_pulse", 64'(event_wr_when_not_capturing), 64'd0);

      // Partial capture and rewind
      rd_req = 1'b1;
      tick();
      chk("part_d0", 64'(rd_data), 64'h300);
      tick();
      chk("part_d1",    64'(rd_data), 64'h301);
      chk("part_last1", 64'(rd_last), 64'd0);
      chk("part_count", 64'(buf_count), 64'd1);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      rd_req = 1'b0;
      chk("rew_vld",   64'(rd_data_vld), 64'd0);
      chk("rew_evr",   64'(event_rd_req_when_not_ready), 64'd0);
      chk("rew_count", 64'(buf_count), 64'd3);
      chk("rew_ready", 64'(readout_ready), 64'd1);
      read_stream("rew_rd", 3, 32'h300);
      chk("rew_drained", 64'(readout_ready), 64'd0);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      chk("rew2_ready", 64'(readout_ready), 64'd1);
      chk("rew2_count", 64'(buf_count), 64'd3);

      // Clear collision with capture_done held high
      capture_done = 1'b1;
      tick();
      clear  = 1'b1;
      rd_req = 1'b1;
      tick();
      clear  = 1'b0;
      rd_req = 1'b0;
      chk("col_vld",   64'(rd_data_vld), 64'd0);
      chk("col_count", 64'(buf_count), 64'd0);
      chk("col_ready", 64'(readout_ready), 64'd0);
      write_word(32'h400);
      write_word(32'h401);
      tick();
      tick();
      chk("held_ready", 64'(readout_ready), 64'd0);
      chk("held_count", 64'(buf_count), 64'd2);
      capture_done = 1'b0;
      tick();
      capture_pulse();
      read_stream("col_rd", 2, 32'h400);

      // Reset mid-readout
      clear_pulse();
      for (int i = 0; i < 8; i++) write_word(32'h500 + DW'(i));
      capture_pulse();
      rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_data", 64'(rd_data), 64'(32'h500 + i));
      end
      rstn = 1'b0;
      tick();
      chk("mrst_vld",   64'(rd_data_vld), 64'd0);
      chk("mrst_data",  64'(rd_data), 64'd0);
      chk("mrst_last",  64'(rd_last), 64'd0);
      chk("mrst_count", 64'(buf_count), 64'd0);
      chk("mrst_ready", 64'(readout_ready), 64'd0);
      chk("mrst_evr",   64'(event_rd_req_when_not_ready), 64'd0);
      rstn   = 1'b1;
      rd_req = 1'b0;
      write_word(32'h600);
      write_word(32'h601);
      chk("post_count", 64'(buf_count), 64'd2);
      capture_pulse();
      read_stream("post_rd", 2, 32'h600);
      chk("post_count0", 64'(buf_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
